// File: rtl/tcm_arbiter.sv
//==============================================================================
// Module      : tcm_arbiter
// Description : Two-master (instruction / data) round-robin arbiter in front
//               of a single-outstanding TCM controller. Grants combinationally
//               in IDLE, waits for the downstream response in WAIT, and
//               converts a missing response into a fault after TMO cycles.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif
`ifndef BUS_ACC_WIDTH
`define BUS_ACC_WIDTH 2
`endif

module tcm_arbiter #(
    parameter int AW  = 14,
    parameter int TMO = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    // instruction port (read-only)
    input  logic [AW-1:0]             i_addr,
    input  logic [`BUS_ACC_WIDTH-1:0] i_acc,
    input  logic                      i_req,
    output logic [`BUS_WIDTH-1:0]     i_rdata,
    output logic                      i_resp,
    output logic                      i_fault,
    // data port
    input  logic [AW-1:0]             d_addr,
    input  logic                      d_w_rb,
    input  logic [`BUS_ACC_WIDTH-1:0] d_acc,
    input  logic [`BUS_WIDTH-1:0]     d_wdata,
    input  logic                      d_req,
    output logic [`BUS_WIDTH-1:0]     d_rdata,
    output logic                      d_resp,
    output logic                      d_fault,
    // downstream to tcm_controller
    output logic [AW-1:0]             s_addr,
    output logic                      s_w_rb,
    output logic [`BUS_ACC_WIDTH-1:0] s_acc,
    output logic [`BUS_WIDTH-1:0]     s_wdata,
    output logic                      s_req,
    input  logic [`BUS_WIDTH-1:0]     s_rdata,
    input  logic                      s_resp,
    input  logic                      s_fault
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    // Counter value on which a still-silent downstream is declared dead.
    localparam logic [7:0] C_TMO_LAST = 8'(TMO - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_last_d;   // 1: most recent grant went to the data port
    logic       r_owner_d;  // 1: outstanding access belongs to the data port
    logic [7:0] r_cnt;
    logic       w_grant_d;
    logic       w_any_req;

    // Read data is shared; each port qualifies it with its own resp.
    assign i_rdata = s_rdata;
    assign d_rdata = s_rdata;

    // Round-robin pick: a sole requester wins, a tie goes to the port not served last.
    always_comb begin
        w_any_req = i_req | d_req;
        w_grant_d = d_req & (~i_req | ~r_last_d);
    end

    // Next-state and all handshake outputs; reset silences every pulse.
    always_comb begin
        w_state_nxt = r_state;
        s_req       = 1'b0;
        s_addr      = w_grant_d ? d_addr : i_addr;
        s_acc       = w_grant_d ? d_acc : i_acc;
        s_w_rb      = w_grant_d & d_w_rb;
        s_wdata     = w_grant_d ? d_wdata : '0;
        i_resp      = 1'b0;
        i_fault     = 1'b0;
        d_resp      = 1'b0;
        d_fault     = 1'b0;
        if (!rst) begin
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        s_req = 1'b1;
                        if (s_fault) begin
                            // Rejected immediately: report and stay ready for the next grant.
                            d_fault = w_grant_d;
                            i_fault = ~w_grant_d;
                        end else begin
                            w_state_nxt = WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (s_resp) begin
                        d_resp      = r_owner_d;
                        i_resp      = ~r_owner_d;
                        w_state_nxt = IDLE;
                    end else if (r_cnt == C_TMO_LAST) begin
                        d_fault     = r_owner_d;
                        i_fault     = ~r_owner_d;
                        w_state_nxt = IDLE;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // State, grant history and response-timeout counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_last_d  <= 1'b0;
            r_owner_d <= 1'b0;
            r_cnt     <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            if (s_req) begin
                r_last_d  <= w_grant_d;
                r_owner_d <= w_grant_d;
            end
            // Held at zero in IDLE so every WAIT entry starts from a clean count.
            if (r_state == IDLE) begin
                r_cnt <= 8'd0;
            end else if (!s_resp) begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_tcm_arbiter.sv
//==============================================================================
// Module      : tb_tcm_arbiter
// Description : Scoreboard bench for tcm_arbiter with a behavioural TCM stub.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif
`ifndef BUS_ACC_WIDTH
`define BUS_ACC_WIDTH 2
`endif

module tb_tcm_arbiter;

    localparam int AW  = 14;
    localparam int TMO = 4;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic [AW-1:0]             i_addr = '0;
    logic [`BUS_ACC_WIDTH-1:0] i_acc = '0;
    logic                      i_req = 1'b0;
    logic [`BUS_WIDTH-1:0]     i_rdata;
    logic                      i_resp, i_fault;
    logic [AW-1:0]             d_addr = '0;
    logic                      d_w_rb = 1'b0;
    logic [`BUS_ACC_WIDTH-1:0] d_acc = '0;
    logic [`BUS_WIDTH-1:0]     d_wdata = '0;
    logic                      d_req = 1'b0;
    logic [`BUS_WIDTH-1:0]     d_rdata;
    logic                      d_resp, d_fault;
    logic [AW-1:0]             s_addr;
    logic                      s_w_rb;
    logic [`BUS_ACC_WIDTH-1:0] s_acc;
    logic [`BUS_WIDTH-1:0]     s_wdata;
    logic                      s_req;
    logic [`BUS_WIDTH-1:0]     s_rdata;
    logic                      s_resp, s_fault;

    tcm_arbiter #(.AW(AW), .TMO(TMO)) dut (
        .clk(clk), .rst(rst),
        .i_addr(i_addr), .i_acc(i_acc), .i_req(i_req),
        .i_rdata(i_rdata), .i_resp(i_resp), .i_fault(i_fault),
        .d_addr(d_addr), .d_w_rb(d_w_rb), .d_acc(d_acc), .d_wdata(d_wdata), .d_req(d_req),
        .d_rdata(d_rdata), .d_resp(d_resp), .d_fault(d_fault),
        .s_addr(s_addr), .s_w_rb(s_w_rb), .s_acc(s_acc), .s_wdata(s_wdata), .s_req(s_req),
        .s_rdata(s_rdata), .s_resp(s_resp), .s_fault(s_fault)
    );

    always #5 clk = ~clk;

    // ---------------- reference rules for the TCM stub ----------------
    function automatic logic [31:0] rom(input logic [AW-1:0] a);
        if (a == 14'h0010) return 32'hDEADBEEF;
        return (32'(a) * 32'h9E3779B1) ^ 32'h5A5A5A5A;
    endfunction

    function automatic bit misaligned(input logic [AW-1:0] a, input logic [1:0] acc);
        case (acc)
            2'd1:    return a[0];
            2'd2:    return a[1:0] != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    // Top quarter of the address space never answers (models a hung target).
    function automatic bit silent(input logic [AW-1:0] a);
        return a[AW-1:AW-2] == 2'b11;
    endfunction

    // ---------------- TCM stub ----------------
    logic        stray = 1'b0;
    logic        pend  = 1'b0;
    logic [31:0] rd_q  = '0;

    assign s_fault = s_req & misaligned(s_addr, s_acc);
    assign s_resp  = pend | stray;
    assign s_rdata = rd_q;

    // One-cycle response for accepted, answerable accesses.
    always @(posedge clk) begin
        pend <= s_req & ~s_fault & ~silent(s_addr);
        rd_q <= rom(s_addr);
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        bit          fault;
        bit          chk_data;
        logic [31:0] data;
        int          lat;
    } exp_t;

    exp_t q_i[$];
    exp_t q_d[$];
    bit   grant_log[$];  // 1 = data port
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   gcyc[2];
    bit   busy = 1'b0;
    bit   last_d = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_port(input int p, input logic resp, input logic fault, input logic [31:0] rdata);
        exp_t e;
        if (!(resp | fault)) return;
        chk(p ? "d_resp_fault_excl" : "i_resp_fault_excl", 64'(resp & fault), 64'd0);
        if ((p ? q_d.size() : q_i.size()) == 0) begin
            chk(p ? "d_unexpected" : "i_unexpected", 64'(resp | fault), 64'd0);
            return;
        end
        e = p ? q_d.pop_front() : q_i.pop_front();
        chk(p ? "d_kind" : "i_kind", 64'(fault), 64'(e.fault));
        chk(p ? "d_latency" : "i_latency", 64'(cyc - gcyc[p]), 64'(e.lat));
        if (e.chk_data && resp) chk(p ? "d_rdata" : "i_rdata", 64'(rdata), 64'(e.data));
    endtask

    // Monitor: models grant decisions from the observed requests and pops expectations.
    initial begin
        bit own;
        bit exp_sreq;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                chk("reset_outputs", {59'd0, s_req, i_resp, i_fault, d_resp, d_fault}, 64'd0);
                busy   = 1'b0;
                last_d = 1'b0;
            end else begin
                exp_sreq = !busy && (i_req || d_req);
                chk("s_req", 64'(s_req), 64'(exp_sreq));
                own = (i_req && d_req) ? !last_d : d_req;
                if (s_req && exp_sreq) begin
                    if (own)
                        chk("d_fields", {s_addr, s_w_rb, s_acc, s_wdata}, {d_addr, d_w_rb, d_acc, d_wdata});
                    else
                        chk("i_fields", {s_addr, s_w_rb, s_acc, s_wdata}, {i_addr, 1'b0, i_acc, 32'h0});
                    last_d    = own;
                    gcyc[own] = cyc;
                    grant_log.push_back(own);
                end
                chk("one_port", 64'((i_resp | i_fault) & (d_resp | d_fault)), 64'd0);
                check_port(0, i_resp, i_fault, i_rdata);
                check_port(1, d_resp, d_fault, d_rdata);
                if (i_resp | i_fault | d_resp | d_fault) busy = 1'b0;
                if (s_req && exp_sreq && !s_fault) busy = 1'b1;
            end
        end
    end

    // ---------------- stimulus ----------------
    // Called #1 after a rising edge; returns #1 after the edge following completion.
    task automatic issue(input bit p, input logic [AW-1:0] a, input logic w,
                         input logic [1:0] acc, input logic [31:0] wd);
        exp_t e;
        bit   mis, sil, done;
        mis        = misaligned(a, acc);
        sil        = silent(a);
        e.fault    = mis || sil;
        e.lat      = mis ? 0 : (sil ? TMO : 1);
        e.chk_data = !e.fault && (!p || !w);
        e.data     = rom(a);
        if (p) begin
            d_addr = a; d_w_rb = w; d_acc = acc; d_wdata = wd;
            q_d.push_back(e);
            d_req = 1'b1;
        end else begin
            i_addr = a; i_acc = acc;
            q_i.push_back(e);
            i_req = 1'b1;
        end
        done = 1'b0;
        for (int n = 0; n < 40 && !done; n++) begin
            @(negedge clk);
            done = p ? (d_resp | d_fault) : (i_resp | i_fault);
        end
        chk(p ? "d_done_timeout" : "i_done_timeout", 64'(done), 64'd1);
        @(posedge clk);
        #1;
        if (p) d_req = 1'b0;
        else   i_req = 1'b0;
    endtask

    task automatic master(input bit p, input int n);
        int            gap;
        int            r;
        logic [AW-1:0] a;
        for (int k = 0; k < n; k++) begin
            gap = $urandom_range(0, 2);
            if (gap != 0) begin
                repeat (gap) @(posedge clk);
                #1;
            end
            r = $urandom_range(0, 9);
            a = (r == 0) ? {2'b11, 12'($urandom)} : 14'($urandom_range(0, 14'h2FFF));
            issue(p, a, p ? 1'($urandom) : 1'b0, 2'($urandom_range(0, 2)), $urandom);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed: data read, data misaligned write, instruction read, timeout, follow-up grant
        issue(1'b1, 14'h010, 1'b0, 2'd2, 32'h0);
        issue(1'b1, 14'h003, 1'b1, 2'd1, 32'h1234_5678);
        issue(1'b0, 14'h020, 1'b0, 2'd0, 32'h0);
        issue(1'b0, 14'h3004, 1'b0, 2'd2, 32'h0);
        issue(1'b1, 14'h044, 1'b0, 2'd2, 32'h0);

        // Both masters held from reset: expect alternating D,I,D,I
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        grant_log.delete();
        fork
            begin issue(1'b1, 14'h100, 1'b0, 2'd2, 32'h0); issue(1'b1, 14'h104, 1'b1, 2'd2, 32'hA5A5_0001); end
            begin issue(1'b0, 14'h200, 1'b0, 2'd2, 32'h0); issue(1'b0, 14'h204, 1'b0, 2'd2, 32'h0); end
        join
        chk("rr_count", 64'(grant_log.size()), 64'd4);
        if (grant_log.size() >= 4)
            chk("rr_order", {60'd0, grant_log[0], grant_log[1], grant_log[2], grant_log[3]}, 64'hA);

        // Reset during WAIT: the late response must not escape, next tie goes to D
        d_addr = 14'h040; d_acc = 2'd2; d_w_rb = 1'b0; d_req = 1'b1;  // granted this cycle
        @(posedge clk);
        #1;
        rst = 1'b1;                                                   // now in WAIT
        @(negedge clk);
        chk("rst_wait_no_resp", {62'd0, i_resp, d_resp}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0; d_req = 1'b0; stray = 1'b1;
        @(negedge clk);
        chk("stray_resp_ignored", {62'd0, i_resp, d_resp}, 64'd0);
        @(posedge clk);
        #1;
        stray = 1'b0;
        grant_log.delete();
        fork
            issue(1'b1, 14'h048, 1'b0, 2'd2, 32'h0);
            issue(1'b0, 14'h04C, 1'b0, 2'd2, 32'h0);
        join
        chk("tie_after_rst", (grant_log.size() > 0) ? 64'(grant_log[0]) : 64'd0, 64'd1);

        // Randomized concurrent traffic
        fork
            master(1'b0, 30);
            master(1'b1, 30);
        join

        repeat (3) @(posedge clk);
        chk("queues_drained", 64'(q_i.size() + q_d.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
